// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between icache, the instruction fetch queue and decode.
// The queue itself uses the slave modport; the icache/decode side uses master.
interface inst_fetch_queue_if #(
  parameter int unsigned depth_width = 3
);
  logic                   icache_fq_valid;
  logic [31:0]            icache_fq_pc;
  logic [63:0]            icache_fq_dout;
  logic                   icache_fq_flag;
  logic                   fq_icache_stall;
  logic                   flush;
  logic                   fq_decode_valid0;
  logic                   fq_decode_valid1;
  logic [31:0]            fq_decode_inst0;
  logic [31:0]            fq_decode_inst1;
  logic [31:0]            fq_decode_pc0;
  logic [31:0]            fq_decode_pc1;
  logic                   decode_fq_ready;
  logic [depth_width:0]   fq_count;

  modport slave (
    input  icache_fq_valid, icache_fq_pc, icache_fq_dout, icache_fq_flag,
    input  flush, decode_fq_ready,
    output fq_icache_stall, fq_decode_valid0, fq_decode_valid1,
    output fq_decode_inst0, fq_decode_inst1, fq_decode_pc0, fq_decode_pc1,
    output fq_count
  );

  modport master (
    output icache_fq_valid, icache_fq_pc, icache_fq_dout, icache_fq_flag,
    output flush, decode_fq_ready,
    input  fq_icache_stall, fq_decode_valid0, fq_decode_valid1,
    input  fq_decode_inst0, fq_decode_inst1, fq_decode_pc0, fq_decode_pc1,
    input  fq_count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Two-in/two-out circular instruction queue decoupling icache from decode.
// Outputs are combinational reads of registered state, masked to 0 when invalid.
module inst_fetch_queue #(
  parameter int unsigned depth_width = 3
) (
  input logic               clk,
  input logic               rstn,
  inst_fetch_queue_if.slave fq
);

  localparam int unsigned DEPTH = 2 ** depth_width;

  typedef logic [depth_width-1:0] ptr_t;
  typedef logic [depth_width:0]   cnt_t;

  logic [63:0] mem_q [DEPTH];

  ptr_t rp_q, rp_d;
  ptr_t wp_q, wp_d;
  cnt_t count_q, count_d;

  ptr_t        rp_p1;
  ptr_t        wp_p1;
  logic [1:0]  push_n;
  logic [1:0]  pop_n;
  logic        valid0;
  logic        valid1;
  logic        stall;
  logic [63:0] ent0;
  logic [63:0] ent1;

  // Stall depends only on registered occupancy: fewer than two free slots.
  assign stall  = (count_q >= cnt_t'(DEPTH - 1));
  assign valid0 = (count_q != '0);
  assign valid1 = (count_q >= cnt_t'(2));
  assign rp_p1  = rp_q + ptr_t'(1);
  assign wp_p1  = wp_q + ptr_t'(1);

  always_comb begin
    push_n = '0;
    pop_n  = '0;
    if (!fq.flush) begin
      if (fq.icache_fq_valid && !stall) begin
        push_n = fq.icache_fq_flag ? 2'd2 : 2'd1;
      end
      if (fq.decode_fq_ready) begin
        pop_n = {1'b0, valid0} + {1'b0, valid1};
      end
    end
  end

  always_comb begin
    rp_d    = rp_q;
    wp_d    = wp_q;
    count_d = count_q;
    if (fq.flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end else begin
      rp_d    = rp_q + ptr_t'(pop_n);
      wp_d    = wp_q + ptr_t'(push_n);
      count_d = count_q + cnt_t'(push_n) - cnt_t'(pop_n);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; stale data never escapes the valid masks.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      mem_q[wp_q] <= {fq.icache_fq_pc, fq.icache_fq_dout[31:0]};
    end
    if (push_n == 2'd2) begin
      mem_q[wp_p1] <= {fq.icache_fq_pc + 32'd4, fq.icache_fq_dout[63:32]};
    end
  end

  assign ent0 = mem_q[rp_q];
  assign ent1 = mem_q[rp_p1];

  assign fq.fq_icache_stall  = stall;
  assign fq.fq_decode_valid0 = valid0;
  assign fq.fq_decode_valid1 = valid1;
  assign fq.fq_decode_inst0  = valid0 ? ent0[31:0]  : '0;
  assign fq.fq_decode_pc0    = valid0 ? ent0[63:32] : '0;
  assign fq.fq_decode_inst1  = valid1 ? ent1[31:0]  : '0;
  assign fq.fq_decode_pc1    = valid1 ? ent1[63:32] : '0;
  assign fq.fq_count         = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-based reference model checked every
// negedge, directed scenarios with literal expectations, and a PC-order check.
module tb_inst_fetch_queue;

  localparam int unsigned DW    = 3;
  localparam int unsigned DEPTH = 2 ** DW;

  logic clk;
  logic rstn;

  inst_fetch_queue_if #(.depth_width(DW)) fq_if ();

  inst_fetch_queue #(.depth_width(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .fq   (fq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: ordered list of {pc, inst} entries.
  logic [63:0] mq[$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn || fq_if.flush) begin
      mq.delete();
    end else begin
      int n;
      int pops;
      bit can_push;
      n        = mq.size();
      can_push = fq_if.icache_fq_valid && (n <= int'(DEPTH) - 2);
      pops     = fq_if.decode_fq_ready ? ((n >= 2) ? 2 : n) : 0;
      repeat (pops) void'(mq.pop_front());
      if (can_push) begin
        mq.push_back({fq_if.icache_fq_pc, fq_if.icache_fq_dout[31:0]});
        if (fq_if.icache_fq_flag)
          mq.push_back({fq_if.icache_fq_pc + 32'd4, fq_if.icache_fq_dout[63:32]});
      end
    end
  end

  bit          seq_chk = 1'b0;
  logic [31:0] seq_pc;

  always @(negedge clk) begin
    logic [63:0] e0, e1;
    int n;
    n  = mq.size();
    e0 = (n >= 1) ? mq[0] : 64'd0;
    e1 = (n >= 2) ? mq[1] : 64'd0;
    chk("count",  64'(fq_if.fq_count), 64'(n));
    chk("stall",  64'(fq_if.fq_icache_stall), 64'(n >= int'(DEPTH) - 1));
    chk("valid0", 64'(fq_if.fq_decode_valid0), 64'(n >= 1));
    chk("valid1", 64'(fq_if.fq_decode_valid1), 64'(n >= 2));
    chk("slot0",  {fq_if.fq_decode_pc0, fq_if.fq_decode_inst0}, e0);
    chk("slot1",  {fq_if.fq_decode_pc1, fq_if.fq_decode_inst1}, e1);
    // Consumed PCs must form an unbroken +4 sequence across the pointer wrap.
    if (seq_chk && rstn && fq_if.decode_fq_ready && !fq_if.flush) begin
      if (fq_if.fq_decode_valid0) begin
        chk("seq_pc0", 64'(fq_if.fq_decode_pc0), 64'(seq_pc));
        seq_pc = seq_pc + 32'd4;
      end
      if (fq_if.fq_decode_valid1) begin
        chk("seq_pc1", 64'(fq_if.fq_decode_pc1), 64'(seq_pc));
        seq_pc = seq_pc + 32'd4;
      end
    end
  end

  // Present inputs, then advance one clock and settle 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [63:0] dout,
                     input logic flag, input logic rdy, input logic fl);
    fq_if.icache_fq_valid = v;
    fq_if.icache_fq_pc    = pc;
    fq_if.icache_fq_dout  = dout;
    fq_if.icache_fq_flag  = flag;
    fq_if.decode_fq_ready = rdy;
    fq_if.flush           = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 32'd0, 64'd0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc;
    rstn = 1'b0;
    fq_if.icache_fq_valid = 1'b0;
    fq_if.icache_fq_pc    = '0;
    fq_if.icache_fq_dout  = '0;
    fq_if.icache_fq_flag  = 1'b0;
    fq_if.decode_fq_ready = 1'b0;
    fq_if.flush           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(fq_if.fq_count), 64'd0);
    chk("rst_stall", 64'(fq_if.fq_icache_stall), 64'd0);
    chk("rst_valid0", 64'(fq_if.fq_decode_valid0), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic two-instruction push
    cyc(1'b1, 32'h1c000000, {32'h02800421, 32'h02800400}, 1'b1, 1'b0, 1'b0);
    chk("basic_count", 64'(fq_if.fq_count), 64'd2);
    chk("basic_v0",    64'(fq_if.fq_decode_valid0), 64'd1);
    chk("basic_v1",    64'(fq_if.fq_decode_valid1), 64'd1);
    chk("basic_inst0", 64'(fq_if.fq_decode_inst0), 64'h02800400);
    chk("basic_pc0",   64'(fq_if.fq_decode_pc0),   64'h1c000000);
    chk("basic_inst1", 64'(fq_if.fq_decode_inst1), 64'h02800421);
    chk("basic_pc1",   64'(fq_if.fq_decode_pc1),   64'h1c000004);

    // Drain, then single push
    idle(1'b1);
    chk("drain_count", 64'(fq_if.fq_count), 64'd0);
    cyc(1'b1, 32'h1c000008, {32'hdeadbeef, 32'h00000013}, 1'b0, 1'b0, 1'b0);
    chk("single_count", 64'(fq_if.fq_count), 64'd1);
    chk("single_v1",    64'(fq_if.fq_decode_valid1), 64'd0);
    chk("single_inst1", 64'(fq_if.fq_decode_inst1), 64'd0);
    chk("single_pc1",   64'(fq_if.fq_decode_pc1), 64'd0);
    chk("single_inst0", 64'(fq_if.fq_decode_inst0), 64'h00000013);
    idle(1'b1);

    // Fill to full, blocked fifth packet, one pop
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'h100 + 32'(8 * i), {32'(i * 2 + 1), 32'(i * 2)}, 1'b1, 1'b0, 1'b0);
      chk("fill_count", 64'(fq_if.fq_count), 64'(2 * (i + 1)));
    end
    chk("full_stall", 64'(fq_if.fq_icache_stall), 64'd1);
    cyc(1'b1, 32'h120, {32'haaaa, 32'h5555}, 1'b1, 1'b0, 1'b0);
    chk("blocked_count", 64'(fq_if.fq_count), 64'd8);
    idle(1'b1);
    chk("pop_count", 64'(fq_if.fq_count), 64'd6);
    chk("pop_stall", 64'(fq_if.fq_icache_stall), 64'd0);
    chk("pop_pc0",   64'(fq_if.fq_decode_pc0), 64'h108);

    // Count 7: push blocked by stall, pop of two proceeds
    cyc(1'b1, 32'h120, {32'h11, 32'h10}, 1'b0, 1'b0, 1'b0);
    chk("c7_count", 64'(fq_if.fq_count), 64'd7);
    chk("c7_stall", 64'(fq_if.fq_icache_stall), 64'd1);
    cyc(1'b1, 32'h124, {32'h13, 32'h12}, 1'b1, 1'b1, 1'b0);
    chk("c7pp_count", 64'(fq_if.fq_count), 64'd5);

    // Flush with packet and ready asserted
    cyc(1'b1, 32'h200, {32'h21, 32'h20}, 1'b1, 1'b1, 1'b1);
    chk("flush_count",  64'(fq_if.fq_count), 64'd0);
    chk("flush_v0",     64'(fq_if.fq_decode_valid0), 64'd0);
    chk("flush_stall",  64'(fq_if.fq_icache_stall), 64'd0);
    idle(1'b0);
    chk("flush_dropped", 64'(fq_if.fq_count), 64'd0);

    // Wrap-around: bursty pushes, mostly-ready decode
    pc      = 32'h1c001000;
    seq_pc  = pc;
    seq_chk = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic v;
      logic acc;
      v   = (i % 4) != 3 && i < 26;
      acc = v && !fq_if.fq_icache_stall;
      cyc(v, pc, {pc ^ 32'h55, pc ^ 32'haa}, 1'b1, (i % 5) != 4, 1'b0);
      if (acc) pc = pc + 32'd8;
    end
    seq_chk = 1'b0;
    chk("wrap_drained", 64'(fq_if.fq_count), 64'd0);
    chk("wrap_seq_end", 64'(seq_pc), 64'(pc));

    // Asynchronous reset mid-fill
    cyc(1'b1, 32'h300, {32'h31, 32'h30}, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h308, {32'h33, 32'h32}, 1'b1, 1'b0, 1'b0);
    chk("prerst_count", 64'(fq_if.fq_count), 64'd4);
    fq_if.icache_fq_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_count",  64'(fq_if.fq_count), 64'd0);
    chk("arst_v0",     64'(fq_if.fq_decode_valid0), 64'd0);
    chk("arst_v1",     64'(fq_if.fq_decode_valid1), 64'd0);
    chk("arst_slot0",  {fq_if.fq_decode_pc0, fq_if.fq_decode_inst0}, 64'd0);
    chk("arst_slot1",  {fq_if.fq_decode_pc1, fq_if.fq_decode_inst1}, 64'd0);
    chk("arst_stall",  64'(fq_if.fq_icache_stall), 64'd0);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 32'h400, {32'h41, 32'h40}, 1'b0, 1'b0, 1'b0);
    chk("post_rst_pc0", 64'(fq_if.fq_decode_pc0), 64'h400);
    chk("post_rst_count", 64'(fq_if.fq_count), 64'd1);
    idle(1'b1);
    idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
